// File: rtl/reaction_controller.sv
// reaction_controller: sequences one reaction-timer round from a Start press
// to a Stop press. Waits a pseudo-random delay, lights the stimulus LED, then
// steps the external BCD counter once per millisecond until Stop or timeout.
// Ports:
//   clk_i           system clock, all state changes on the rising edge
//   rst_i           asynchronous active-high reset
//   start_i/stop_i  debounced synchronous button levels (only rises act)
//   led_o           stimulus light, high only while measuring
//   count_clear_o   one-cycle clear pulse to the counter (ARM)
//   count_step_o    one-cycle enable pulse to the counter, once per ms
//   elapsed_ms_o    binary count of step pulses issued this round
//   false_start_o   Stop pressed before the LED
//   timed_out_o     no Stop within TIMEOUT_MS
//   busy_o          round in progress (ARM, WAIT, MEASURE)
// Latency: Start/Stop rise acts on the edge that samples it; outputs are
// decoded from registers only, so no input reaches an output combinationally.

module reaction_controller #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  output logic        led_o,
  output logic        count_clear_o,
  output logic        count_step_o,
  output logic [13:0] elapsed_ms_o,
  output logic        false_start_o,
  output logic        timed_out_o,
  output logic        busy_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Wide enough for MIN_DELAY_MS + 2^RAND_BITS - 1 without overflow.
  localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] MIN_DLY   = DW'(MIN_DELAY_MS);
  localparam logic [13:0]   TMO       = 14'(TIMEOUT_MS);
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_MEASURE,
    S_DONE,
    S_FAULT,
    S_TIMEOUT
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [13:0]   elapsed_q, elapsed_d;
  logic          step_q, step_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          start_q, stop_q;

  logic          start_rise;
  logic          stop_rise;
  logic          tick;
  logic [DW-1:0] addend;

  // Rise = low at the previous edge, high at this one.
  assign start_rise = start_i & ~start_q;
  assign stop_rise  = stop_i & ~stop_q;
  assign tick       = (presc_q == TICK_LAST);
  assign addend     = {{(DW - RAND_BITS){1'b0}}, lfsr_q[RAND_BITS-1:0]};

  // Fibonacci LFSR, taps 16,14,13,11; never all-zero from a non-zero seed.
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      delay_q   <= '0;
      elapsed_q <= '0;
      step_q    <= 1'b0;
      lfsr_q    <= LFSR_SEED;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      delay_q   <= delay_d;
      elapsed_q <= elapsed_d;
      step_q    <= step_d;
      lfsr_q    <= lfsr_d;
      start_q   <= start_i;
      stop_q    <= stop_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    delay_d   = delay_q;
    elapsed_d = elapsed_q;
    step_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d   = S_ARM;
          elapsed_d = '0;
        end
      end

      S_ARM: begin
        delay_d = MIN_DLY + addend;
        presc_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // A Stop rise beats a coinciding tick.
        if (stop_rise) begin
          state_d = S_FAULT;
        end else if (tick) begin
          if (delay_q == DW'(1)) begin
            state_d = S_MEASURE;
            presc_d = '0;
          end else begin
            delay_d = delay_q - 1'b1;
          end
        end
      end

      S_MEASURE: begin
        // Stop on a tick edge ends the round without issuing that step.
        if (stop_rise) begin
          state_d = S_DONE;
        end else if (tick) begin
          step_d    = 1'b1;
          elapsed_d = elapsed_q + 14'd1;
          if (elapsed_q + 14'd1 == TMO) begin
            state_d = S_TIMEOUT;
          end
        end
      end

      S_DONE, S_FAULT, S_TIMEOUT: begin
        if (start_rise) begin
          state_d   = S_ARM;
          elapsed_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign led_o         = (state_q == S_MEASURE);
  assign count_clear_o = (state_q == S_ARM);
  assign count_step_o  = step_q;
  assign elapsed_ms_o  = elapsed_q;
  assign false_start_o = (state_q == S_FAULT);
  assign timed_out_o   = (state_q == S_TIMEOUT);
  assign busy_o        = (state_q == S_ARM) || (state_q == S_WAIT) || (state_q == S_MEASURE);

endmodule

// File: tb/tb_reaction_controller.sv
// Self-checking bench for reaction_controller with small timing parameters.
module tb_reaction_controller;

  localparam int TICK_DIV     = 4;
  localparam int MIN_DELAY_MS = 2;
  localparam int RAND_BITS    = 2;
  localparam int TIMEOUT_MS   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        led, clr, step, fs, to, busy;
  logic [13:0] elapsed;

  int checks = 0;
  int failures = 0;

  int step_cnt = 0;
  int clr_cnt = 0;
  bit led_seen = 1'b0;
  bit both_seen = 1'b0;

  logic [15:0] m_lfsr;
  int exp_q[$];

  always #5 clk = ~clk;

  reaction_controller #(
    .TICK_DIV(TICK_DIV),
    .MIN_DELAY_MS(MIN_DELAY_MS),
    .RAND_BITS(RAND_BITS),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .stop_i(stop),
    .led_o(led),
    .count_clear_o(clr),
    .count_step_o(step),
    .elapsed_ms_o(elapsed),
    .false_start_o(fs),
    .timed_out_o(to),
    .busy_o(busy)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR: seeded on reset, advances every clock.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lfsr_step(m_lfsr);
  end

  // One clock; outputs sampled on the falling edge.
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
    if (step) step_cnt++;
    if (clr) clr_cnt++;
    if (led) led_seen = 1'b1;
    if (step && clr) both_seen = 1'b1;
  endtask

  task automatic clear_obs;
    step_cnt = 0;
    clr_cnt = 0;
    led_seen = 1'b0;
  endtask

  task automatic wait_led(output int k, output bit ok);
    k = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      k++;
      if (led) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (led !== 1'b0) begin failures++; $display("FAIL rst_led got=%0b exp=0", led); end
    checks++; if (clr !== 1'b0) begin failures++; $display("FAIL rst_clear got=%0b exp=0", clr); end
    checks++; if (step !== 1'b0) begin failures++; $display("FAIL rst_step got=%0b exp=0", step); end
    checks++; if (elapsed !== 14'd0) begin failures++; $display("FAIL rst_elapsed got=%0d exp=0", elapsed); end
    checks++; if (fs !== 1'b0) begin failures++; $display("FAIL rst_false_start got=%0b exp=0", fs); end
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL rst_timed_out got=%0b exp=0", to); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    rst = 1'b0;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wait_busy got=%0b exp=1", busy); end
    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy got=%0b exp=0", busy); end
    checks++; if (led !== 1'b0 || clr !== 1'b0 || step !== 1'b0) begin failures++; $display("FAIL async_rst_pulses got=%0b%0b%0b exp=000", led, clr, step); end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (clr !== 1'b1) begin failures++; $display("FAIL arm_clear got=%0b exp=1", clr); end
    cyc();
    checks++; if (clr !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL wait_entry clr=%0b busy=%0b exp clr=0 busy=1", clr, busy); end
    stop = 1'b1; cyc(); stop = 1'b0;
    checks++; if (fs !== 1'b1) begin failures++; $display("FAIL rst_exit_fault got=%0b exp=1", fs); end
  endtask

  task automatic test_normal_round;
    int k;
    bit ok;
    logic [15:0] nx;
    // Press Start on the edge that leaves LFSR addend 1 visible in ARM.
    nx = lfsr_step(m_lfsr);
    for (int i = 0; i < 64 && nx[1:0] != 2'd1; i++) begin
      cyc();
      nx = lfsr_step(m_lfsr);
    end
    exp_q.push_back((MIN_DELAY_MS + 1) * TICK_DIV);
    exp_q.push_back(2);
    exp_q.push_back(2);
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (clr !== 1'b1) begin failures++; $display("FAIL normal_arm_clear got=%0b exp=1", clr); end
    cyc();
    clear_obs();
    wait_led(k, ok);
    checks++; if (!ok || k !== exp_q.pop_front()) begin failures++; $display("FAIL normal_led_delay got=%0d ok=%0b exp=12", k, ok); end
    repeat (8) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    checks++; if (led !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL normal_done led=%0b busy=%0b exp 0 0", led, busy); end
    checks++; if (elapsed !== 14'(exp_q.pop_front())) begin failures++; $display("FAIL normal_elapsed got=%0d exp=2", elapsed); end
    checks++; if (step_cnt !== exp_q.pop_front()) begin failures++; $display("FAIL normal_steps got=%0d exp=2", step_cnt); end
    checks++; if (step !== 1'b0 || fs !== 1'b0 || to !== 1'b0) begin failures++; $display("FAIL normal_flags step=%0b fs=%0b to=%0b exp 000", step, fs, to); end
  endtask

  task automatic test_false_start;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    clear_obs();
    repeat (2) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    checks++; if (fs !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL fault_state fs=%0b busy=%0b exp 1 0", fs, busy); end
    repeat (20) cyc();
    checks++; if (led_seen !== 1'b0 || step_cnt !== 0) begin failures++; $display("FAIL fault_quiet led_seen=%0b steps=%0d exp 0 0", led_seen, step_cnt); end
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (clr !== 1'b1 || busy !== 1'b1 || fs !== 1'b0) begin failures++; $display("FAIL fault_rearm clr=%0b busy=%0b fs=%0b exp 1 1 0", clr, busy, fs); end
  endtask

  task automatic test_timeout;
    int k;
    bit ok;
    exp_q.push_back(TIMEOUT_MS * TICK_DIV);
    exp_q.push_back(TIMEOUT_MS);
    exp_q.push_back(TIMEOUT_MS);
    cyc();
    clear_obs();
    wait_led(k, ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_led got=none exp=rise"); end
    k = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      k++;
      if (to) break;
    end
    checks++; if (k !== exp_q.pop_front()) begin failures++; $display("FAIL timeout_cycles got=%0d exp=20", k); end
    checks++; if (step !== 1'b1) begin failures++; $display("FAIL timeout_final_step got=%0b exp=1", step); end
    checks++; if (step_cnt !== exp_q.pop_front()) begin failures++; $display("FAIL timeout_steps got=%0d exp=5", step_cnt); end
    checks++; if (elapsed !== 14'(exp_q.pop_front())) begin failures++; $display("FAIL timeout_elapsed got=%0d exp=5", elapsed); end
    repeat (10) cyc();
    checks++; if (to !== 1'b1 || led !== 1'b0 || step_cnt !== 5 || elapsed !== 14'd5) begin failures++; $display("FAIL timeout_hold to=%0b led=%0b steps=%0d elapsed=%0d exp 1 0 5 5", to, led, step_cnt, elapsed); end
  endtask

  task automatic test_stop_on_tick;
    int k;
    bit ok;
    start = 1'b1; cyc();
    checks++; if (clr !== 1'b1) begin failures++; $display("FAIL tick_arm_clear got=%0b exp=1", clr); end
    cyc();
    clear_obs();
    wait_led(k, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tick_led got=none exp=rise"); end
    repeat (3) cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    checks++; if (busy !== 1'b0 || led !== 1'b0 || step !== 1'b0) begin failures++; $display("FAIL tick_done busy=%0b led=%0b step=%0b exp 000", busy, led, step); end
    checks++; if (step_cnt !== 0 || elapsed !== 14'd0) begin failures++; $display("FAIL tick_no_step steps=%0d elapsed=%0d exp 0 0", step_cnt, elapsed); end
    repeat (12) cyc();
    checks++; if (clr_cnt !== 0 || busy !== 1'b0) begin failures++; $display("FAIL held_start_rearm clears=%0d busy=%0b exp 0 0", clr_cnt, busy); end
    start = 1'b0; cyc();
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (clr !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL repress_arm clr=%0b busy=%0b exp 1 1", clr, busy); end
  endtask

  task automatic test_reset_measure;
    int k;
    bit ok;
    cyc();
    wait_led(k, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstm_led got=none exp=rise"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (led !== 1'b0 || busy !== 1'b0 || step !== 1'b0 || elapsed !== 14'd0) begin failures++; $display("FAIL rstm_async led=%0b busy=%0b step=%0b elapsed=%0d exp 0 0 0 0", led, busy, step, elapsed); end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstm_idle got=%0b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_normal_round();
    test_false_start();
    test_timeout();
    test_stop_on_tick();
    test_reset_measure();
    checks++; if (both_seen !== 1'b0) begin failures++; $display("FAIL step_clear_overlap got=%0b exp=0", both_seen); end
    checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reaction_controller.md
# reaction_controller

Sequencing controller for the reaction-timer datapath: runs one measurement round from a Start press to a Stop press. It waits a pseudo-random delay, lights the stimulus LED, and steps the 4-digit BCD counter once per millisecond until Stop arrives. It sits between the debounced push-buttons and the BCD counter/display and drives the counter's Reset and Enable inputs. It also detects false starts (Stop before the LED) and timeouts.

## Interface
- TICK_DIV, 50000: Clock cycles per millisecond tick (≥2).
- MIN_DELAY_MS, 1000: fixed part of the pre-stimulus delay, in ms (≥1).
- RAND_BITS, 11: width of the random delay addend; addend range 0..2^RAND_BITS−1 ms.
- TIMEOUT_MS, 9999: ms steps in MEASURE before the round is abandoned.
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high; forces all state below.
- Start  in  1  debounced, synchronous Start button, level.
- Stop  in  1  debounced, synchronous Stop/react button, level.
- Led  out  1  stimulus light; 1 only in MEASURE.
- CountClear  out  1  one-cycle pulse to the counter's Reset, in ARM.
- CountStep  out  1  one-cycle pulse to the counter's Enable, once per ms in MEASURE.
- ElapsedMs  out  14  binary count of CountStep pulses issued this round.
- FalseStart  out  1  1 while in FAULT.
- TimedOut  out  1  1 while in TIMEOUT.
- Busy  out  1  1 in ARM, WAIT, MEASURE.

## Operation
- Edge detect: a rise is registered Start/Stop = 0 on the previous edge and 1 on this edge. Only rises act; held levels are ignored.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Seed 16'hACE1 on Reset. It advances every cycle in every state and never reaches all-zero.
- Prescaler: counts 0..TICK_DIV−1 and clears on entry to WAIT and MEASURE. A tick is the cycle where it equals TICK_DIV−1.
- States and transitions:
  - IDLE: Start rise → ARM.
  - ARM: exactly one cycle. CountClear=1, ElapsedMs←0, Delay←MIN_DELAY_MS + LFSR[RAND_BITS−1:0]. Then → WAIT.
  - WAIT: each tick decrements Delay. A tick with Delay==1 → MEASURE. A Stop rise → FAULT, with priority over the tick.
  - MEASURE: Led=1. A tick asserts CountStep and increments ElapsedMs. A Stop rise → DONE with no CountStep that cycle, even on a tick. A tick that makes ElapsedMs reach TIMEOUT_MS asserts that final CountStep, then → TIMEOUT.
  - DONE, FAULT, TIMEOUT: hold. Led=0, the counter is left untouched so the display keeps its value, ElapsedMs is frozen. A Start rise → ARM.
- Start rises in ARM, WAIT and MEASURE are ignored. Stop rises in IDLE, DONE, FAULT and TIMEOUT are ignored.
- Delay arithmetic is unsigned and wide enough for MIN_DELAY_MS + 2^RAND_BITS−1 with no overflow. ElapsedMs saturates by construction at TIMEOUT_MS, which must be ≤9999.
- Reset mid-round, asynchronous, in any state: → IDLE immediately. Led, CountClear and CountStep deassert without waiting for a clock.

## Timing
- All outputs are registered Moore/state-decoded; no combinational path from Start/Stop to any output.
- Reset values: state IDLE, Led 0, CountClear 0, CountStep 0, ElapsedMs 0, FalseStart 0, TimedOut 0, Busy 0, prescaler 0, LFSR 16'hACE1.
- Start rise sampled at edge n: ARM outputs valid after edge n, WAIT after edge n+1.
- Stimulus delay: Led rises exactly Delay×TICK_DIV cycles after WAIT entry.
- The first CountStep comes TICK_DIV cycles after MEASURE entry, then one every TICK_DIV cycles.
- Stop rise at edge n in MEASURE: Led=0 and DONE after edge n. The final ElapsedMs equals the counter's BCD value.
- CountStep and CountClear are never asserted in the same cycle.

## Test plan
Bench parameters: TICK_DIV=4, MIN_DELAY_MS=2, RAND_BITS=2, TIMEOUT_MS=5.
- Reset asserted mid-WAIT with no clock edge → all outputs at reset values immediately. Release, then Start rise → one-cycle CountClear, then Busy=1.
- Normal round, LFSR addend 1 → Led rises 12 cycles after WAIT entry. Stop rise 9 cycles later → DONE, ElapsedMs=2, exactly 2 CountStep pulses.
- Stop rise 3 cycles into WAIT → FAULT, FalseStart=1, Led never 1, no CountStep. Next Start rise → ARM.
- No Stop in MEASURE → 5 CountStep pulses, TIMEOUT after the 5th, TimedOut=1, ElapsedMs=5.
- Stop rise on the same edge as a tick in MEASURE → DONE, no CountStep, ElapsedMs unchanged. Start held high through the whole round → no re-arm until released and pressed again.
